// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS register-file widths, zero-register constant and index type
//
// Purpose : common constants for the decode-side operand fetch slice.
// Contents: DATA_W   - operand / writeback data width
//           REG_AW   - register index width (2**REG_AW registers)
//           REG_ZERO - hard-wired zero register index
//           reg_idx_t - register index type
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits with set-wins update and bypass-aware lookup
//
// Purpose : tracks registers that have an issued-but-not-written-back producer.
// Ports   : clk, rst_n            - clock, asynchronous active-low reset
//           set_en, set_idx       - mark a register busy (new owner issued)
//           clr_en, clr_idx       - writeback clears the register's busy bit
//           look_a/b/c_idx        - indices to look up
//           look_a/b/c_busy       - effective busy: busy and not being written back this cycle
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic [REG_AW-1:0] look_a_idx,
  input  logic [REG_AW-1:0] look_b_idx,
  input  logic [REG_AW-1:0] look_c_idx,
  output logic              look_a_busy,
  output logic              look_b_busy,
  output logic              look_c_busy
);

  localparam int NREGS = 2 ** REG_AW;

  logic [NREGS-1:0] busy;

  // Clear first, then set, so an issue that claims a register in the same
  // cycle its previous owner writes back leaves the bit set for the new owner.
  // Register zero is never marked busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en && set_idx != REG_AW'(REG_ZERO)) busy[set_idx] <= 1'b1;
    end
  end

  // A writeback this cycle satisfies the dependency through the bypass path.
  assign look_a_busy = busy[look_a_idx] && !(clr_en && clr_idx == look_a_idx);
  assign look_b_busy = busy[look_b_idx] && !(clr_en && clr_idx == look_b_idx);
  assign look_c_busy = busy[look_c_idx] && !(clr_en && clr_idx == look_c_idx);

endmodule

// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - register-file operand fetch with writeback bypass, hazard stall and issue register
//
// Purpose : reads rs/rt from the register file, bypasses same-cycle writeback,
//           stalls on RAW/WAW hazards and issues through a one-entry output register.
// Ports   : clk, rst_n                      - clock, asynchronous active-low reset
//           in_valid/in_ready, in_rs/rt/rd, in_wen - decoded instruction handshake
//           rf_read_reg1/2, rf_read_data1/2 - register file read ports
//           wb_valid, wb_reg, wb_data       - writeback strobe and data
//           out_valid/out_ready, out_op_a/b, out_rd, out_wen - issue to execute
//           stall_count                     - saturating count of stalled cycles
module operand_fetch_unit
  import mips_pkg::*;
#(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_AW  = mips_pkg::REG_AW,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [REG_AW-1:0]  in_rs,
  input  logic [REG_AW-1:0]  in_rt,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic               in_wen,
  output logic [REG_AW-1:0]  rf_read_reg1,
  output logic [REG_AW-1:0]  rf_read_reg2,
  input  logic [DATA_W-1:0]  rf_read_data1,
  input  logic [DATA_W-1:0]  rf_read_data2,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_reg,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_op_a,
  output logic [DATA_W-1:0]  out_op_b,
  output logic [REG_AW-1:0]  out_rd,
  output logic               out_wen,
  output logic [STALL_W-1:0] stall_count
);

  logic busy_rs, busy_rt, busy_rd;
  logic hazard;
  logic issue;
  logic [DATA_W-1:0] op_a, op_b;

  assign rf_read_reg1 = in_rs;
  assign rf_read_reg2 = in_rt;

  reg_scoreboard #(
    .REG_AW (REG_AW)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en      (issue && in_wen),
    .set_idx     (in_rd),
    .clr_en      (wb_valid),
    .clr_idx     (wb_reg),
    .look_a_idx  (in_rs),
    .look_b_idx  (in_rt),
    .look_c_idx  (in_rd),
    .look_a_busy (busy_rs),
    .look_b_busy (busy_rt),
    .look_c_busy (busy_rd)
  );

  // WAW only matters when this instruction actually writes its destination.
  assign hazard   = busy_rs || busy_rt || (in_wen && busy_rd);
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign issue    = in_valid && in_ready;

  // Register zero reads as zero regardless of register file or bypass.
  always_comb begin
    op_a = rf_read_data1;
    if (in_rs == REG_AW'(REG_ZERO))           op_a = '0;
    else if (wb_valid && wb_reg == in_rs)     op_a = wb_data;
  end

  always_comb begin
    op_b = rf_read_data2;
    if (in_rt == REG_AW'(REG_ZERO))           op_b = '0;
    else if (wb_valid && wb_reg == in_rt)     op_b = wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op_a  <= '0;
      out_op_b  <= '0;
      out_rd    <= '0;
      out_wen   <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_op_a  <= op_a;
      out_op_b  <= op_b;
      out_rd    <= in_rd;
      out_wen   <= in_wen;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (in_valid && !in_ready && stall_count != '1) begin
      stall_count <= stall_count + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb/tb_operand_fetch_unit.sv - directed self-checking bench for operand_fetch_unit
module tb_operand_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_wen;
  logic [4:0]  rf_read_reg1, rf_read_reg2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op_a, out_op_b;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  operand_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs         (in_rs),
    .in_rt         (in_rt),
    .in_rd         (in_rd),
    .in_wen        (in_wen),
    .rf_read_reg1  (rf_read_reg1),
    .rf_read_reg2  (rf_read_reg2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op_a      (out_op_a),
    .out_op_b      (out_op_b),
    .out_rd        (out_rd),
    .out_wen       (out_wen),
    .stall_count   (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic wen,
                       input logic [31:0] d1, input logic [31:0] d2);
    in_valid      = v;
    in_rs         = rs;
    in_rt         = rt;
    in_rd         = rd;
    in_wen        = wen;
    rf_read_data1 = d1;
    rf_read_data2 = d2;
    #1;
  endtask

  task automatic wb(input logic v, input logic [4:0] r, input logic [31:0] d);
    wb_valid = v;
    wb_reg   = r;
    wb_data  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_stall", stall_count, 0);
    check("rst_op_a", out_op_a, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // independent stream rd=1,2,3
    instr(1'b1, 5'd10, 5'd11, 5'd1, 1'b1, 32'h11, 32'h22);
    check("ind_ready1", in_ready, 1);
    check("rf_reg1", rf_read_reg1, 10);
    check("rf_reg2", rf_read_reg2, 11);
    step();
    check("ind_valid1", out_valid, 1);
    check("ind_op_a1", out_op_a, 32'h11);
    check("ind_op_b1", out_op_b, 32'h22);
    check("ind_rd1", out_rd, 1);
    instr(1'b1, 5'd10, 5'd11, 5'd2, 1'b1, 32'h33, 32'h44);
    check("ind_ready2", in_ready, 1);
    step();
    check("ind_rd2", out_rd, 2);
    check("ind_op_a2", out_op_a, 32'h33);
    instr(1'b1, 5'd10, 5'd11, 5'd3, 1'b1, 32'h55, 32'h66);
    check("ind_ready3", in_ready, 1);
    step();
    check("ind_rd3", out_rd, 3);
    instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    step();
    check("ind_drain", out_valid, 0);
    check("ind_stall", stall_count, 0);
    instr(1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    check("busy1", in_ready, 0);
    instr(1'b0, 5'd0, 5'd2, 5'd0, 1'b0, 32'h0, 32'h0);
    check("busy2", in_ready, 0);
    instr(1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 32'h0, 32'h0);
    check("busy3_waw", in_ready, 0);
    instr(1'b0, 5'd4, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    check("free4", in_ready, 1);
    instr(1'b0, 5'd0, 5'd0, 5'd3, 1'b0, 32'h0, 32'h0);
    check("rd3_no_wen", in_ready, 1);
    for (int r = 1; r <= 3; r++) begin
      wb(1'b1, 5'(r), 32'h0);
      step();
    end
    wb(1'b0, 5'd0, 32'h0);
    instr(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0, 32'h0);
    check("cleared123", in_ready, 1);

    // RAW stall plus bypass
    instr(1'b1, 5'd10, 5'd11, 5'd5, 1'b1, 32'h1, 32'h2);
    step();
    instr(1'b1, 5'd5, 5'd11, 5'd0, 1'b0, 32'h55, 32'h77);
    for (int i = 0; i < 3; i++) begin
      check("raw_stall", in_ready, 0);
      step();
    end
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("raw_wb_ready", in_ready, 1);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check("raw_op_a", out_op_a, 32'hDEADBEEF);
    check("raw_op_b", out_op_b, 32'h77);
    check("raw_stall_cnt", stall_count, 3);
    instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    step();

    // register zero overrides rf data and bypass
    wb(1'b1, 5'd0, 32'h1234);
    instr(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check("zero_op_a", out_op_a, 0);
    check("zero_op_b", out_op_b, 0);
    check("zero_wen", out_wen, 1);
    instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
    check("zero_not_busy", in_ready, 1);
    step();

    // backpressure
    out_ready = 1'b0;
    instr(1'b1, 5'd12, 5'd13, 5'd8, 1'b1, 32'hA1, 32'hB2);
    step();
    instr(1'b1, 5'd14, 5'd15, 5'd9, 1'b1, 32'hC3, 32'hD4);
    for (int i = 0; i < 4; i++) begin
      check("bp_ready", in_ready, 0);
      step();
    end
    check("bp_valid", out_valid, 1);
    check("bp_op_a", out_op_a, 32'hA1);
    check("bp_op_b", out_op_b, 32'hB2);
    check("bp_rd", out_rd, 8);
    check("bp_stall", stall_count, 7);
    out_ready = 1'b1;
    #1;
    check("bp_release", in_ready, 1);
    step();
    check("bp_next_a", out_op_a, 32'hC3);
    check("bp_next_rd", out_rd, 9);
    check("bp_stall_hold", stall_count, 7);

    // set wins over simultaneous writeback clear
    instr(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0);
    step();
    wb(1'b1, 5'd7, 32'h0);
    #1;
    check("sw_ready", in_ready, 1);
    step();
    wb(1'b0, 5'd0, 32'h0);
    instr(1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    check("sw_busy7", in_ready, 0);

    // reset mid-operation
    instr(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 32'h0, 32'h0);
    step();
    instr(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 32'h9, 32'h0);
    step();
    out_ready = 1'b0;
    instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    step();
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_stall", stall_count, 0);
    check("arst_rd", out_rd, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    instr(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 32'h33, 32'h44);
    check("post_rst_ready", in_ready, 1);
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_op_a", out_op_a, 32'h33);
    check("post_rst_stall", stall_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
